// File: rtl/axi4_lite_master_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
// Response codes, protection default and engine state encodings.
package axi4_lite_master_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_RESP,
        W_DONE
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_DONE
    } rstate_e;

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        unique case (resp)
            RESP_OKAY:   err = 1'b0;
            RESP_EXOKAY: err = 1'b1;
            RESP_SLVERR: err = 1'b1;
            RESP_DECERR: err = 1'b1;
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi4_lite_master_bridge_write_channel.sv
// Store engine: drives AW and W together, tracks each handshake
// separately, then collects the B response.
module axi4_lite_write_channel
    import axi4_lite_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic [DATA_WIDTH/8-1:0]   strb_i,
    output wstate_e                   state_o,
    output logic                      busy_o,
    output logic                      error_o,
    output logic [ADDR_WIDTH-1:0]     awaddr_o,
    output logic [2:0]                awprot_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   wstrb_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    input  logic [1:0]                bresp_i,
    input  logic                      bvalid_i,
    output logic                      bready_o
);

    wstate_e                  state_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH/8-1:0]  strb_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     bready_q;
    logic                     aw_done_q;
    logic                     w_done_q;
    logic                     err_q;

    logic aw_hs_d;
    logic w_hs_d;
    logic both_done_d;

    assign aw_hs_d     = awvalid_q & awready_i;
    assign w_hs_d      = wvalid_q & wready_i;
    assign both_done_d = (aw_done_q | aw_hs_d) & (w_done_q | w_hs_d);

    // Store FSM with registered bus outputs and one-cycle error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                W_IDLE: begin
                    if (start_i) begin
                        addr_q    <= addr_i;
                        data_q    <= data_i;
                        strb_q    <= strb_i;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs_d) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs_d) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (both_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid_i) begin
                        bready_q <= 1'b0;
                        err_q    <= resp_is_err(bresp_i);
                        state_q  <= W_DONE;
                    end
                end
                W_DONE: state_q <= W_IDLE;
                default: state_q <= W_IDLE;
            endcase
        end
    end

    assign state_o   = state_q;
    assign busy_o    = start_i && (state_q != W_DONE);
    assign error_o   = err_q;
    assign awaddr_o  = addr_q;
    assign awprot_o  = PROT_DEFAULT;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = data_q;
    assign wstrb_o   = strb_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

endmodule

// File: rtl/axi4_lite_master_bridge.sv
// Memory-stage load/store to AXI4-Lite master bridge.
// Store engine is a sub-block; the load engine yields to it.
module axi4_lite_master_bridge
    import axi4_lite_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_start,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_strobe,
    output logic                      write_busy,
    output logic                      write_error,
    input  logic                      read_start,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      read_busy,
    output logic                      read_error,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    wstate_e wstate;

    axi4_lite_write_channel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_write (
        .clk       (clk),
        .rst       (rst),
        .start_i   (write_start),
        .addr_i    (write_addr),
        .data_i    (write_data),
        .strb_i    (write_strobe),
        .state_o   (wstate),
        .busy_o    (write_busy),
        .error_o   (write_error),
        .awaddr_o  (m_awaddr),
        .awprot_o  (m_awprot),
        .awvalid_o (m_awvalid),
        .awready_i (m_awready),
        .wdata_o   (m_wdata),
        .wstrb_o   (m_wstrb),
        .wvalid_o  (m_wvalid),
        .wready_i  (m_wready),
        .bresp_i   (m_bresp),
        .bvalid_i  (m_bvalid),
        .bready_o  (m_bready)
    );

    rstate_e                rstate_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic                   arvalid_q;
    logic                   rready_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   rerr_q;
    logic                   rd_accept_d;

    // Loads wait while a store is pending or in flight.
    assign rd_accept_d = read_start && (wstate == W_IDLE) && !write_start;

    // Load FSM; read_data holds the last captured RDATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate_q  <= R_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            rerr_q <= 1'b0;
            unique case (rstate_q)
                R_IDLE: begin
                    if (rd_accept_d) begin
                        araddr_q  <= read_addr;
                        arvalid_q <= 1'b1;
                        rstate_q  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_rvalid) begin
                        rdata_q  <= m_rdata;
                        rerr_q   <= resp_is_err(m_rresp);
                        rready_q <= 1'b0;
                        rstate_q <= R_DONE;
                    end
                end
                R_DONE: rstate_q <= R_IDLE;
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign read_busy  = read_start && (rstate_q != R_DONE);
    assign read_data  = rdata_q;
    assign read_error = rerr_q;
    assign m_araddr   = araddr_q;
    assign m_arprot   = PROT_DEFAULT;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;

endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
- Downstream of the memory stage: converts the stage's start/addr/data/strobe load-store requests into AXI4-Lite master transactions.
- Returns load data and a busy signal that stalls the pipeline until the bus completes.
- One write engine (AW/W/B) and one read engine (AR/R); the write engine has priority.
- Sits between the memory stage and the AXI4-Lite interconnect/peripherals.

Parameters:
ADDR_WIDTH, 32, address width of request and AXI address channels
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
write_start  input  1  store request, held high by the core while stalled
write_addr  input  ADDR_WIDTH  store address
write_data  input  DATA_WIDTH  store data (unshifted)
write_strobe  input  DATA_WIDTH/8  byte enables from the memory stage
write_busy  output  1  store not yet complete; stalls pipeline
write_error  output  1  one-cycle pulse, BRESP != OKAY
read_start  input  1  load request, held high while stalled
read_addr  input  ADDR_WIDTH  load address
read_data  output  DATA_WIDTH  registered RDATA of the last completed read
read_busy  output  1  load not yet complete; stalls pipeline
read_error  output  1  one-cycle pulse, RRESP != OKAY
m_awaddr/m_awprot/m_awvalid  output  ADDR_WIDTH/3/1  AW channel; awprot = 3'b000
m_awready  input  1  AW ready
m_wdata/m_wstrb/m_wvalid  output  DATA_WIDTH/DATA_WIDTH/8/1  W channel
m_wready  input  1  W ready
m_bresp/m_bvalid  input  2/1  B channel
m_bready  output  1  B ready
m_araddr/m_arprot/m_arvalid  output  ADDR_WIDTH/3/1  AR channel; arprot = 3'b000
m_arready  input  1  AR ready
m_rdata/m_rresp/m_rvalid  input  DATA_WIDTH/2/1  R channel
m_rready  output  1  R ready

Behaviour:
- Reset (rst=0, async): both FSMs IDLE; all m_*valid, m_bready, m_rready = 0; read_data = 0; error outputs = 0; address/data registers = 0.
- Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_DONE -> W_IDLE.
  - W_IDLE: when write_start = 1, register addr, data and strobe, then go to W_ADDR.
  - W_ADDR: assert awvalid and wvalid together. Track aw_done and w_done flags independently; each valid drops the cycle after its own handshake. Leave W_ADDR when both are done, including the same-cycle case.
  - W_RESP: bready = 1. On bvalid, go to W_DONE; write_error = (bresp != 2'b00), registered.
  - W_DONE: lasts one cycle.
- write_busy = write_start && (wstate != W_DONE). The pipeline advances on the W_DONE edge.
- W_DONE never accepts a new request. A back-to-back store is accepted in W_IDLE on the following cycle.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_DONE -> R_IDLE.
  - R_IDLE accepts read_start only when wstate == W_IDLE and write_start == 0 (write priority).
  - R_ADDR: arvalid held until arready.
  - R_DATA: rready = 1. On rvalid, capture rdata into read_data; read_error = (rresp != 2'b00).
- read_busy = read_start && (rstate != R_DONE).
- read_data stays stable from R_DONE until the next R_DATA capture.
- Minimum latency with zero-wait slave and responses one cycle after address: start in cycle 0, valid in cycle 1, response in cycle 2, DONE in cycle 3. That is 3 stall cycles.
- AXI rules:
  - A valid, once asserted, is never dropped and its payload never changes before the handshake.
  - Payloads come from internal registers, not from live inputs.
- A request deasserted mid-transaction (flush) has no effect: the transaction completes and busy simply reads 0.
- Slave errors do not retry; data is still returned or discarded as normal.
- Both starts high in IDLE: write proceeds; read_busy stays 1 until the write reaches W_DONE; the read is accepted afterwards.
- Reset mid-transaction: immediate return to IDLE with valids low. No completion or error pulse.

Decomposition:
- Shared defines header holds:
  - AXI response codes: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Write and read FSM state encodings.
  - PROT default 3'b000.
- One natural sub-module: axi4_lite_write_channel (W_* FSM, AW/W/B logic).
- The read engine stays inline in the top.

Test Plan:
- SW: write_start, addr 0x0000_0010, data 0xDEAD_BEEF, strobe 4'b1111; zero-wait slave with bvalid one cycle after the handshake -> awaddr 0x10 and wstrb 4'hF on the bus; write_busy high for exactly 3 cycles; no write_error.
- SB with awready delayed 4 cycles and wready immediate: strobe 4'b0100 -> wvalid drops after 1 cycle; awvalid and awaddr held stable for 4 cycles; completes after AW handshake + B.
- LW from 0x20 with slave rdata 0x1234_5678 after 2 wait cycles -> read_data = 0x1234_5678 in R_DONE; read_busy low exactly one cycle after the R handshake; value held afterwards.
- Both starts high together -> AW issued first; arvalid stays 0 until W_DONE; both complete in order.
- Slave returns rresp = 2'b10 -> one-cycle read_error pulse; read_busy releases normally.
- rst asserted while awvalid = 1 -> all valids 0 asynchronously; after release write_busy = write_start, and a new transaction starts cleanly.
